// File: rtl/if_id_inst_queue.sv
// if_id_inst_queue: decoupling FIFO between the IF and ID stages.
// IF pushes fetched entries whenever the queue has room; ID pops the head
// in strict fetch order. A flush (exception, ertn, taken-branch redirect)
// discards every queued entry.
//
// Handshake: a transfer happens on a rising edge where the producer's valid
// and the consumer's ready are both high. IF->queue uses fs_to_ds_valid with
// iq_allowin as ready. Queue->ID uses iq_to_ds_valid with ds_allowin as ready.
// iq_allowin depends only on queue state, never on ds_allowin. While
// iq_flush is high, no transfer happens on either side.
module if_id_inst_queue #(
    parameter int BUS_WD = 81,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fs_to_ds_valid,
    input  logic [BUS_WD-1:0]          fs_to_ds_bus,
    output logic                       iq_allowin,
    output logic                       iq_to_ds_valid,
    output logic [BUS_WD-1:0]          iq_to_ds_bus,
    input  logic                       ds_allowin,
    input  logic                       iq_flush,
    output logic [$clog2(DEPTH):0]     iq_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // Storage is left unreset; only the pointers define which entries are live.
    logic [BUS_WD-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic empty;
    logic full;
    logic push;
    logic pop;

    // Derive occupancy status and the handshakes from the pointer pair.
    always_comb begin
        empty          = (wr_ptr == rd_ptr);
        full           = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                         (wr_ptr[AW] != rd_ptr[AW]);
        iq_allowin     = !full;
        iq_to_ds_valid = !empty;
        push           = fs_to_ds_valid && iq_allowin && !iq_flush;
        pop            = iq_to_ds_valid && ds_allowin && !iq_flush;
        iq_count       = wr_ptr - rd_ptr;
    end

    // Present the head entry to ID, zeroed when there is nothing to present.
    always_comb begin
        iq_to_ds_bus = '0;
        if (!empty) begin
            iq_to_ds_bus = mem[rd_ptr[AW-1:0]];
        end
    end

    // Write the incoming entry into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= fs_to_ds_bus;
        end
    end

    // Advance the pointers; reset and flush both collapse the queue to empty.
    always_ff @(posedge clk) begin
        if (reset || iq_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_if_id_inst_queue.sv
// Directed bench for if_id_inst_queue: reset, fill, drain with concurrent
// push, pointer wrap, flush, exception entry delivery.
module tb_if_id_inst_queue;

    localparam int BUS_WD = 81;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              reset;
    logic              fs_to_ds_valid;
    logic [BUS_WD-1:0] fs_to_ds_bus;
    logic              iq_allowin;
    logic              iq_to_ds_valid;
    logic [BUS_WD-1:0] iq_to_ds_bus;
    logic              ds_allowin;
    logic              iq_flush;
    logic [2:0]        iq_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    if_id_inst_queue #(.BUS_WD(BUS_WD), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .iq_allowin     (iq_allowin),
        .iq_to_ds_valid (iq_to_ds_valid),
        .iq_to_ds_bus   (iq_to_ds_bus),
        .ds_allowin     (ds_allowin),
        .iq_flush       (iq_flush),
        .iq_count       (iq_count)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Entry with a distinct inst field per pc, no exception.
    function automatic logic [BUS_WD-1:0] mk(input logic [31:0] pc);
        return {pc, ~pc, 1'b0, 16'h0000};
    endfunction

    // One clock edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [BUS_WD-1:0] obs,
                         input logic [BUS_WD-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [BUS_WD-1:0] bus,
                         input logic rdy, input logic fl);
        fs_to_ds_valid = v;
        fs_to_ds_bus   = bus;
        ds_allowin     = rdy;
        iq_flush       = fl;
    endtask

    initial begin
        logic [BUS_WD-1:0] excp_entry;
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);

        // T1 reset
        tick();
        tick();
        reset = 1'b0;
        check("t1_valid",   BUS_WD'(iq_to_ds_valid), BUS_WD'(0));
        check("t1_allowin", BUS_WD'(iq_allowin),     BUS_WD'(1));
        check("t1_count",   BUS_WD'(iq_count),       BUS_WD'(0));
        check("t1_bus",     iq_to_ds_bus,            '0);

        // T2 fill with ID stalled
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, mk(32'h1c000000 + 32'(4 * i)), 1'b0, 1'b0);
            tick();
            check("t2_count", BUS_WD'(iq_count), BUS_WD'(i + 1));
        end
        check("t2_allowin_full", BUS_WD'(iq_allowin), BUS_WD'(0));
        drive(1'b1, mk(32'h1c000010), 1'b0, 1'b0);
        tick();
        check("t2_count_held", BUS_WD'(iq_count), BUS_WD'(4));
        check("t2_head",       iq_to_ds_bus,      mk(32'h1c000000));

        // T3 drain to 2, then push+pop together for 3 cycles
        drive(1'b0, '0, 1'b1, 1'b0);
        check("t3_pop0", iq_to_ds_bus, mk(32'h1c000000));
        tick();
        check("t3_pop1", iq_to_ds_bus, mk(32'h1c000004));
        tick();
        check("t3_count2", BUS_WD'(iq_count), BUS_WD'(2));
        drive(1'b1, mk(32'h1c000020), 1'b1, 1'b0);
        check("t3_head_a", iq_to_ds_bus, mk(32'h1c000008));
        tick();
        check("t3_count_a", BUS_WD'(iq_count), BUS_WD'(2));
        drive(1'b1, mk(32'h1c000024), 1'b1, 1'b0);
        check("t3_head_b", iq_to_ds_bus, mk(32'h1c00000c));
        tick();
        check("t3_count_b", BUS_WD'(iq_count), BUS_WD'(2));
        drive(1'b1, mk(32'h1c000028), 1'b1, 1'b0);
        check("t3_head_c", iq_to_ds_bus, mk(32'h1c000020));
        tick();
        check("t3_count_c", BUS_WD'(iq_count), BUS_WD'(2));
        drive(1'b0, '0, 1'b1, 1'b0);
        check("t3_drain_a", iq_to_ds_bus, mk(32'h1c000024));
        tick();
        check("t3_drain_b", iq_to_ds_bus, mk(32'h1c000028));
        tick();
        check("t3_empty_count", BUS_WD'(iq_count),       BUS_WD'(0));
        check("t3_empty_valid", BUS_WD'(iq_to_ds_valid), BUS_WD'(0));

        // T4 wrap-around: 11 single entries, ID ready during the push cycle too
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, mk(32'h1c001000 + 32'(4 * i)), 1'b1, 1'b0);
            check("t4_no_bypass", BUS_WD'(iq_to_ds_valid), BUS_WD'(0));
            tick();
            drive(1'b0, '0, 1'b1, 1'b0);
            check("t4_count1", BUS_WD'(iq_count), BUS_WD'(1));
            check("t4_head",   iq_to_ds_bus,      mk(32'h1c001000 + 32'(4 * i)));
            tick();
            check("t4_count0", BUS_WD'(iq_count), BUS_WD'(0));
        end

        // T5 flush with concurrent push and pop request
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk(32'h1c000040 + 32'(4 * i)), 1'b0, 1'b0);
            tick();
        end
        check("t5_count3", BUS_WD'(iq_count), BUS_WD'(3));
        drive(1'b1, mk(32'h1c00004c), 1'b1, 1'b1);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        check("t5_count0",  BUS_WD'(iq_count),       BUS_WD'(0));
        check("t5_valid0",  BUS_WD'(iq_to_ds_valid), BUS_WD'(0));
        check("t5_bus0",    iq_to_ds_bus,            '0);
        check("t5_allowin", BUS_WD'(iq_allowin),     BUS_WD'(1));
        drive(1'b1, mk(32'h1c000100), 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        check("t5_count1", BUS_WD'(iq_count), BUS_WD'(1));
        check("t5_head",   iq_to_ds_bus,      mk(32'h1c000100));
        tick();
        check("t5_drained", BUS_WD'(iq_count), BUS_WD'(0));

        // T6 exception entry passes through untouched
        excp_entry = {32'h1c000002, 32'h00000000, 1'b1, 16'h4000};
        drive(1'b1, excp_entry, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        check("t6_valid", BUS_WD'(iq_to_ds_valid), BUS_WD'(1));
        check("t6_bus",   iq_to_ds_bus,            excp_entry);
        tick();
        check("t6_held",  iq_to_ds_bus,            excp_entry);

        // reset together with flush clears the queue
        drive(1'b1, mk(32'h1c000200), 1'b0, 1'b0);
        tick();
        check("rf_count2", BUS_WD'(iq_count), BUS_WD'(2));
        reset = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b1);
        tick();
        reset = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        check("rf_count0", BUS_WD'(iq_count),       BUS_WD'(0));
        check("rf_valid0", BUS_WD'(iq_to_ds_valid), BUS_WD'(0));

        // final report
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
